// File: rtl/floyd_tb_pkg.sv
// floyd_tb_pkg
//   Definitions shared by the Floyd-Warshall result scanner and its bench:
//   the scanner state encoding and the default geometry of the kernel's
//   path memory.
package floyd_tb_pkg;

  localparam int PATH_WIDTH  = 32;
  localparam int PATH_SIZE   = 64;
  localparam int PATH_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/floyd_result_scanner.sv
// floyd_result_scanner
//   Sweeps the kernel's DUT memory and a golden memory through shared read
//   ports, then reports the mismatch count, the lowest mismatching address
//   and the sum of all DUT words (mod 2^WIDTH).
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start            begin a scan (accepted only in IDLE or DONE)
//   busy             high from the cycle after an accepted start through done
//   done             one-cycle pulse, results final
//   rd_en, rd_addr   shared read port to both memories (1-cycle latency)
//   dut_rd_data      DUT memory read data
//   gold_rd_data     golden memory read data
//   mismatch_count   number of differing addresses
//   first_err_valid  at least one mismatch seen
//   first_err_addr   lowest differing address
//   checksum         sum of DUT words, carry discarded
//
// State | Meaning
//   IDLE  | waiting for start
//   READ  | issuing reads at addresses 0..SIZE-1
//   DRAIN | last read word in the compare stage
//   DONE  | results final, done pulsed
module floyd_result_scanner
  import floyd_tb_pkg::*;
#(
  parameter int WIDTH  = PATH_WIDTH,
  parameter int SIZE   = PATH_SIZE,
  parameter int ADDR_W = PATH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  dut_rd_data,
  input  logic [WIDTH-1:0]  gold_rd_data,
  output logic [ADDR_W:0]   mismatch_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [WIDTH-1:0]  checksum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  scan_state_t       state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              cmp_valid_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  logic [ADDR_W:0]   mismatch_count_q, mismatch_count_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [WIDTH-1:0]  checksum_q, checksum_d;

  logic start_acc;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            state_q   <= DRAIN;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          done_q <= 1'b0;
          // Holding start through DONE chains straight into the next sweep.
          if (start) begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Compare stage: read data arrives one cycle after rd_en, so the
  // address travels alongside it to tag the first mismatch.
  always_comb begin
    mismatch_count_d  = mismatch_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_addr_d  = first_err_addr_q;
    checksum_d        = checksum_q;
    if (start_acc) begin
      // first_err_addr is qualified by first_err_valid, so it is left as is.
      mismatch_count_d  = '0;
      first_err_valid_d = 1'b0;
      checksum_d        = '0;
    end else if (cmp_valid_q) begin
      checksum_d = checksum_q + dut_rd_data;
      if (dut_rd_data != gold_rd_data) begin
        mismatch_count_d = mismatch_count_q + (ADDR_W + 1)'(1);
        if (!first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_addr_d  = cmp_addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid_q       <= 1'b0;
      cmp_addr_q        <= '0;
      mismatch_count_q  <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      checksum_q        <= '0;
    end else begin
      cmp_valid_q       <= rd_en_q;
      cmp_addr_q        <= rd_addr_q;
      mismatch_count_q  <= mismatch_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_addr_q  <= first_err_addr_d;
      checksum_q        <= checksum_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign mismatch_count  = mismatch_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_addr  = first_err_addr_q;
  assign checksum        = checksum_q;

endmodule

// File: tb/tb_floyd_result_scanner.sv
// Bench for floyd_result_scanner: directed vector table, start-while-busy
// and back-to-back sequence, reset mid-scan, then randomized memories
// graded against a simple array-walking model.
module tb_floyd_result_scanner;

  localparam int W = 32;
  localparam int S = 64;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [W-1:0] dut_rd_data;
  logic [W-1:0] gold_rd_data;
  logic [A:0]   mismatch_count;
  logic         first_err_valid;
  logic [A-1:0] first_err_addr;
  logic [W-1:0] checksum;

  logic [W-1:0] dut_mem  [S];
  logic [W-1:0] gold_mem [S];

  int n_pass  = 0;
  int n_total = 0;

  floyd_result_scanner #(.WIDTH(W), .SIZE(S), .ADDR_W(A)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .dut_rd_data     (dut_rd_data),
    .gold_rd_data    (gold_rd_data),
    .mismatch_count  (mismatch_count),
    .first_err_valid (first_err_valid),
    .first_err_addr  (first_err_addr),
    .checksum        (checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      dut_rd_data  <= dut_mem[rd_addr];
      gold_rd_data <= gold_mem[rd_addr];
    end
  end

  typedef struct {
    string        name;
    int           kind;
    int           exp_mc;
    bit           exp_fev;
    int           exp_fea;
    logic [W-1:0] exp_sum;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // 0 identical, 1 single error at 32, 2 all differ, 3 all ones
  task automatic fill(input int kind);
    for (int i = 0; i < S; i++) begin
      gold_mem[i] = W'(i);
      dut_mem[i]  = W'(i);
      case (kind)
        1: if (i == 32) dut_mem[i] = '0;
        2: dut_mem[i] = W'(i + 1);
        3: begin dut_mem[i] = '1; gold_mem[i] = '1; end
        default: ;
      endcase
    end
  endtask

  task automatic fill_random(input int rate);
    for (int i = 0; i < S; i++) begin
      gold_mem[i] = $urandom;
      dut_mem[i]  = gold_mem[i];
      if (rate > 0 && $urandom_range(0, 99) < rate) dut_mem[i] = gold_mem[i] ^ ($urandom | 32'h1);
    end
  endtask

  task automatic model(output int mc, output bit fev, output int fea, output logic [W-1:0] sum);
    mc = 0; fev = 0; fea = 0; sum = '0;
    for (int i = 0; i < S; i++) begin
      sum = sum + dut_mem[i];
      if (dut_mem[i] != gold_mem[i]) begin
        if (mc == 0) begin fev = 1; fea = i; end
        mc++;
      end
    end
  endtask

  // Runs one scan of S+2 cycles. With 'already' set, start is already
  // high from the previous scan's DONE cycle.
  task automatic run_scan(input string tag, input bit already, input bit pulse_mid,
                          input bit restart, input int exp_mc, input bit exp_fev,
                          input int exp_fea, input logic [W-1:0] exp_sum);
    int terr = 0;
    int dcnt = 0;
    int dcyc = -1;
    if (!already) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= S + 2; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      start = (pulse_mid && c == 20) || (restart && c == S + 2);
      @(negedge clk);
      if (c == 1) begin
        chk({tag, " cleared mismatch_count"}, mismatch_count, 0);
        chk({tag, " cleared checksum"}, checksum, 0);
        chk({tag, " cleared first_err_valid"}, first_err_valid, 0);
      end
      if (rd_en != (c <= S)) terr++;
      if (rd_en && rd_addr != A'(c - 1)) terr++;
      if (busy != (c <= S + 2)) terr++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
    end
    chk({tag, " rd_en/rd_addr/busy timing errors"}, terr, 0);
    chk({tag, " done pulses"}, dcnt, 1);
    chk({tag, " done cycle"}, dcyc, S + 2);
    chk({tag, " mismatch_count"}, mismatch_count, exp_mc);
    chk({tag, " first_err_valid"}, first_err_valid, exp_fev);
    if (exp_fev) chk({tag, " first_err_addr"}, first_err_addr, exp_fea);
    chk({tag, " checksum"}, checksum, exp_sum);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " rd_addr"}, rd_addr, 0);
    chk({tag, " mismatch_count"}, mismatch_count, 0);
    chk({tag, " first_err_valid"}, first_err_valid, 0);
    chk({tag, " first_err_addr"}, first_err_addr, 0);
    chk({tag, " checksum"}, checksum, 0);
  endtask

  initial begin
    vec_t vecs [4];
    int mc, fea, dcnt;
    bit fev;
    logic [W-1:0] sum;

    vecs[0] = '{"identical",    0,  0, 0,  0, 32'd2016};
    vecs[1] = '{"single error", 1,  1, 1, 32, 32'd1984};
    vecs[2] = '{"all differ",   2, 64, 1,  0, 32'd2080};
    vecs[3] = '{"wrap",         3,  0, 0,  0, 32'hFFFF_FFC0};

    rst = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].kind);
      run_scan(vecs[v].name, 1'b0, 1'b0, 1'b0, vecs[v].exp_mc, vecs[v].exp_fev,
               vecs[v].exp_fea, vecs[v].exp_sum);
      repeat (3) @(negedge clk);
      chk({vecs[v].name, " idle busy"}, busy, 0);
      chk({vecs[v].name, " hold checksum"}, checksum, vecs[v].exp_sum);
    end

    // start while busy, then restart from DONE into a different data set
    fill(2);
    run_scan("busy first", 1'b0, 1'b1, 1'b1, 64, 1'b1, 0, 32'd2080);
    fill(0);
    run_scan("back-to-back", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 32'd2016);

    // reset at cycle 10 of a scan
    fill(2);
    dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= S + 10; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      rst = (c == 10);
      @(negedge clk);
      if (c == 9) chk("pre-reset mismatch_count", mismatch_count, 7);
      if (c == 11) check_all_zero("after reset");
      if (c == 12) begin
        chk("reset discard mismatch_count", mismatch_count, 0);
        chk("reset discard checksum", checksum, 0);
      end
      if (c > 10 && done) dcnt++;
    end
    chk("reset no done", dcnt, 0);
    fill(1);
    model(mc, fev, fea, sum);
    run_scan("post-reset", 1'b0, 1'b0, 1'b0, mc, fev, fea, sum);

    for (int r = 0; r < 6; r++) begin
      fill_random(r == 0 ? 0 : r * 8);
      model(mc, fev, fea, sum);
      run_scan($sformatf("random%0d", r), 1'b0, 1'b0, 1'b0, mc, fev, fea, sum);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/floyd_result_scanner.md
# floyd_result_scanner

Post-kernel result checker for the Floyd-Warshall benches. It sits directly downstream of the kernel's `path` memory. After the kernel finishes, it sweeps every word of the DUT memory and a golden memory through `memref_rd`-style read ports. It reports the mismatch count, the first mismatching address and a modular checksum, so the bench can grade the HIR and HLS instances identically.

## Interface
Parameters:
- `WIDTH`, 32: data word width.
- `SIZE`, 64: number of words scanned; must be ≥ 2.
- `ADDR_W`, 6: address width; `2**ADDR_W` ≥ `SIZE`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a scan; sampled only in IDLE or DONE.
- `busy`  out  1  high from the cycle after an accepted start through the cycle done is high.
- `done`  out  1  one-cycle pulse when results are final.
- `rd_en`  out  1  read enable, shared by both memories.
- `rd_addr`  out  ADDR_W  read address, shared by both memories.
- `dut_rd_data`  in  WIDTH  DUT memory data; valid one cycle after `rd_en`.
- `gold_rd_data`  in  WIDTH  golden memory data; same latency.
- `mismatch_count`  out  ADDR_W+1  number of addresses where DUT ≠ gold.
- `first_err_valid`  out  1  at least one mismatch seen.
- `first_err_addr`  out  ADDR_W  lowest mismatching address.
- `checksum`  out  WIDTH  sum of all DUT words mod 2^WIDTH.

## Operation
- States:
  - IDLE: after reset.
  - READ: `rd_en` = 1, `rd_addr` counts 0..SIZE-1.
  - DRAIN: last word compared.
  - DONE: one cycle, `done` = 1; then returns to IDLE.
- Transitions:
  - IDLE, `start` → READ.
  - READ with `rd_addr` = SIZE-1 → DRAIN.
  - DRAIN → DONE.
  - DONE → IDLE. If `start` = 1 in DONE, go directly to READ.
- Start handling:
  - `start` is ignored in READ and DRAIN.
  - An accepted start clears `mismatch_count`, `checksum` and `first_err_valid` in the same edge.
- Compare stage:
  - Registered `cmp_valid` and `cmp_addr` delay `rd_en` and `rd_addr` by one cycle.
  - When `cmp_valid` is high, the stage adds `dut_rd_data` to `checksum`, wrapping and discarding the carry.
  - On a mismatch it increments `mismatch_count`. If `first_err_valid` = 0, it also loads `first_err_addr` = `cmp_addr` and sets `first_err_valid`.
- `mismatch_count` is sized to hold SIZE, so it never saturates.
- Results hold their values after DONE until the next accepted start or `rst`.
- The block never writes memory.

## Timing
- Reset value of every output is 0: `busy`, `done`, `rd_en`, `rd_addr`, `mismatch_count`, `first_err_valid`, `first_err_addr`, `checksum`. The internal `cmp_valid` also resets to 0.
- With `start` sampled at edge 0:
  - `rd_en` is high for cycles 1..SIZE, with `rd_addr` = cycle−1.
  - Compares occur at cycles 2..SIZE+1.
  - `done` is high at cycle SIZE+2; for SIZE = 64, that is cycle 66.
  - Results are stable at that cycle.
- `busy` is high for cycles 1..SIZE+2.
- Back-to-back scans: `start` held during DONE is accepted, so `rd_en` rises on the cycle after the `done` pulse.
- Reset during a scan: the state returns to IDLE on the next edge and all outputs return to 0. No partial results are retained, and any in-flight compare is discarded.

## Structure
- Shared package `floyd_tb_pkg`:
  - state enum `scan_state_t`: IDLE, READ, DRAIN, DONE;
  - default constants `PATH_WIDTH` = 32, `PATH_SIZE` = 64, `PATH_ADDR_W` = 6.
- A single module with no sub-module. The address counter, compare register and FSM are small enough to stay flat.

## Test plan
- **Identical memories:** gold[i] = dut[i] = i.
  - Response: `done` at cycle 66, `mismatch_count` = 0, `first_err_valid` = 0, `checksum` = 2016.
- **Single error:** gold[i] = i, dut identical except dut[32] = 0.
  - Response: `mismatch_count` = 1, `first_err_addr` = 32, `checksum` = 1984.
- **All differ:** dut[i] = i+1, gold[i] = i.
  - Response: `mismatch_count` = 64, `first_err_addr` = 0, `checksum` = 2080.
- **Checksum wrap:** all dut words 0xFFFFFFFF, gold equal to dut.
  - Response: `checksum` = 0xFFFFFFC0, `mismatch_count` = 0.
- **Start while busy:** `start` pulsed at cycles 0 and 20, then reused during DONE.
  - Response: a single `done` at cycle 66.
  - The second scan's `rd_en` rises at cycle 67, and its results are re-cleared on acceptance.
- **Reset mid-scan:** `rst` asserted at cycle 10 for one cycle.
  - Response: all outputs are 0 on the following cycle and no `done` pulse appears.
  - A new start then completes normally with correct values.
